// File: rtl/clk_meter_pkg.sv
// Shared types and defaults for the clock period meter.
// State encoding plus default synchronizer, counter and timeout sizes.
package clk_meter_pkg;

  typedef enum logic [1:0] {
    WAIT_FIRST   = 2'd0,
    FIRST_PERIOD = 2'd1,
    TRACK        = 2'd2
  } meter_state_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_TIMEOUT     = 1000000;

endpackage

// File: rtl/sig_sync_edge.sv
// Synchronizer, priming counter and edge detector for slow async inputs.
// Reused for button and step inputs as well as the period meter.
module sig_sync_edge
  import clk_meter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  localparam int PW = $clog2(SYNC_STAGES + 2);
  localparam logic [PW-1:0] PRIME_N = PW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [PW-1:0]          r_prime;
  logic                   w_last;
  logic                   w_primed;

  assign w_last   = r_sync[SYNC_STAGES-1];
  assign w_primed = (r_prime == PRIME_N);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_prev  <= 1'b0;
      r_prime <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_prev <= w_last;
      if (!w_primed)
        r_prime <= r_prime + 1'b1;
    end
  end

  // Edges are masked until the chain has flushed its reset contents
  assign rise = w_primed & w_last & ~r_prev;
  assign fall = w_primed & ~w_last & r_prev;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow async square wave in CLK_in
// cycles, with lock and stall reporting.
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             CLK_in,
  input  logic             RST,
  input  logic             sig_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             stalled
);

  meter_state_e     r_state;
  meter_state_e     w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic             r_pv;
  logic             r_locked;
  logic             r_stalled;

  logic w_rise;
  logic w_fall;
  logic w_timeout;
  logic w_lat_per;
  logic w_lat_high;
  logic w_upd_lock;
  logic w_stall;
  logic w_clr_stall;

  sig_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (CLK_in),
    .rst   (RST),
    .sig_in(sig_in),
    .rise  (w_rise),
    .fall  (w_fall)
  );

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge CLK_in) begin
    if (RST) r_state <= WAIT_FIRST;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_lat_per   = 1'b0;
    w_lat_high  = 1'b0;
    w_upd_lock  = 1'b0;
    w_stall     = 1'b0;
    w_clr_stall = 1'b0;
    unique case (r_state)
      WAIT_FIRST: begin
        if (w_rise) begin
          w_next      = FIRST_PERIOD;
          w_clr_stall = 1'b1;
        end
      end
      FIRST_PERIOD, TRACK: begin
        w_lat_high = w_fall;
        // A rise landing on the timeout cycle wins over the stall
        if (w_rise) begin
          w_lat_per  = 1'b1;
          w_upd_lock = (r_state == TRACK);
          w_next     = TRACK;
        end else if (w_timeout) begin
          w_stall = 1'b1;
          w_next  = WAIT_FIRST;
        end
      end
      default: w_next = WAIT_FIRST;
    endcase
  end

  always_ff @(posedge CLK_in) begin
    if (RST) begin
      r_cnt     <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_pv      <= 1'b0;
      r_locked  <= 1'b0;
      r_stalled <= 1'b0;
    end else begin
      if (w_rise)
        r_cnt <= CNT_W'(1);
      else if (r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;
      r_pv <= w_lat_per;
      if (w_lat_per)
        r_period <= r_cnt;
      if (w_lat_high)
        r_high <= r_cnt;
      if (w_upd_lock)
        r_locked <= (r_cnt == r_period);
      if (w_stall) begin
        r_stalled <= 1'b1;
        r_locked  <= 1'b0;
      end
      if (w_clr_stall)
        r_stalled <= 1'b0;
    end
  end

  assign rise_pulse   = w_rise;
  assign fall_pulse   = w_fall;
  assign period       = r_period;
  assign high_time    = r_high;
  assign period_valid = r_pv;
  assign locked       = r_locked;
  assign stalled      = r_stalled;

endmodule
